// File: rtl/n101_i2c_master_xfer_seq.sv
// ============================================================================
//  Module      : n101_i2c_master_xfer_seq
//  Description : Sequences single-register I2C reads/writes as a series of
//                byte-controller commands (start/write/read/stop).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module n101_i2c_master_xfer_seq #(
    parameter logic [15:0] TO_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       busy,
    output logic       start,
    output logic       stop,
    output logic       read,
    output logic       write,
    output logic       ack_in,
    output logic [7:0] din,
    input  logic       cmd_ack,
    input  logic       ack_out,
    input  logic       i2c_al,
    input  logic [7:0] dout
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_DEV_W  = 4'd1,
        S_GAP    = 4'd2,
        S_REG_W  = 4'd3,
        S_DATA_W = 4'd4,
        S_DEV_R  = 4'd5,
        S_RD     = 4'd6,
        S_STOP   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    localparam logic [1:0]  c_err_ok   = 2'd0;
    localparam logic [1:0]  c_err_nack = 2'd1;
    localparam logic [1:0]  c_err_al   = 2'd2;
    localparam logic [1:0]  c_err_to   = 2'd3;
    // The counter lands on TO_CYCLES-1 in the same cycle DONE becomes visible.
    localparam logic [15:0] c_to_trip  = TO_CYCLES - 16'd2;

    state_t      r_state, w_state_nxt;
    state_t      r_gap_tgt, w_gap_tgt_nxt;
    logic [15:0] r_to_cnt, w_to_cnt_nxt;
    logic [1:0]  r_err, w_err_nxt;
    logic [6:0]  r_dev;
    logic [7:0]  r_reg;
    logic [7:0]  r_wdata;
    logic        r_rnw;
    logic        w_latch;
    logic        w_cmd_state;
    logic [6:0]  w_dev;

    logic        r_req_ready, r_rsp_valid, r_busy;
    logic [7:0]  r_rsp_rdata, w_rdata_nxt;
    logic [1:0]  r_rsp_err;
    logic        r_start, r_stop, r_read, r_write, r_ack_in;
    logic [7:0]  r_din;
    logic        w_start_nxt, w_stop_nxt, w_read_nxt, w_write_nxt, w_ack_in_nxt;
    logic [7:0]  w_din_nxt;

    assign w_cmd_state = (r_state == S_DEV_W) || (r_state == S_REG_W) ||
                         (r_state == S_DATA_W) || (r_state == S_DEV_R) ||
                         (r_state == S_RD) || (r_state == S_STOP);
    assign w_dev       = w_latch ? req_dev : r_dev;

    // Next-state, error and read-data decisions
    always_comb begin
        w_state_nxt   = r_state;
        w_gap_tgt_nxt = r_gap_tgt;
        w_err_nxt     = r_err;
        w_rdata_nxt   = r_rsp_rdata;
        w_to_cnt_nxt  = 16'd0;
        w_latch       = 1'b0;
        if (w_cmd_state) begin
            if (i2c_al) begin
                w_err_nxt   = c_err_al;
                w_state_nxt = S_DONE;
            end else if (cmd_ack) begin
                w_state_nxt = S_GAP;
                case (r_state)
                    S_DEV_W: begin
                        if (ack_out) begin
                            w_err_nxt     = c_err_nack;
                            w_gap_tgt_nxt = S_STOP;
                        end else begin
                            w_gap_tgt_nxt = S_REG_W;
                        end
                    end
                    S_REG_W: begin
                        if (ack_out) begin
                            w_err_nxt     = c_err_nack;
                            w_gap_tgt_nxt = S_STOP;
                        end else begin
                            w_gap_tgt_nxt = r_rnw ? S_DEV_R : S_DATA_W;
                        end
                    end
                    S_DATA_W: begin
                        w_err_nxt   = ack_out ? c_err_nack : c_err_ok;
                        w_state_nxt = S_DONE;
                    end
                    S_DEV_R: begin
                        if (ack_out) begin
                            w_err_nxt     = c_err_nack;
                            w_gap_tgt_nxt = S_STOP;
                        end else begin
                            w_gap_tgt_nxt = S_RD;
                        end
                    end
                    S_RD: begin
                        w_rdata_nxt = dout;
                        w_err_nxt   = c_err_ok;
                        w_state_nxt = S_DONE;
                    end
                    S_STOP: begin
                        w_state_nxt = S_DONE;
                    end
                    default: begin
                        w_state_nxt = S_DONE;
                    end
                endcase
            end else if (r_to_cnt == c_to_trip) begin
                w_err_nxt    = c_err_to;
                w_state_nxt  = S_DONE;
                w_to_cnt_nxt = r_to_cnt + 16'd1;
            end else begin
                w_to_cnt_nxt = r_to_cnt + 16'd1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        w_latch     = 1'b1;
                        w_err_nxt   = c_err_ok;
                        w_state_nxt = S_DEV_W;
                    end
                end
                S_GAP:   w_state_nxt = r_gap_tgt;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Command outputs are decoded from the next state so they register with it
    always_comb begin
        w_start_nxt  = 1'b0;
        w_stop_nxt   = 1'b0;
        w_read_nxt   = 1'b0;
        w_write_nxt  = 1'b0;
        w_ack_in_nxt = 1'b0;
        w_din_nxt    = 8'h00;
        case (w_state_nxt)
            S_DEV_W: begin
                w_start_nxt = 1'b1;
                w_write_nxt = 1'b1;
                w_din_nxt   = {w_dev, 1'b0};
            end
            S_REG_W: begin
                w_write_nxt = 1'b1;
                w_din_nxt   = r_reg;
            end
            S_DATA_W: begin
                w_write_nxt = 1'b1;
                w_stop_nxt  = 1'b1;
                w_din_nxt   = r_wdata;
            end
            S_DEV_R: begin
                w_start_nxt = 1'b1;
                w_write_nxt = 1'b1;
                w_din_nxt   = {r_dev, 1'b1};
            end
            S_RD: begin
                w_read_nxt   = 1'b1;
                w_stop_nxt   = 1'b1;
                w_ack_in_nxt = 1'b1;
            end
            S_STOP: begin
                w_stop_nxt = 1'b1;
            end
            default: begin
                w_din_nxt = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gap_tgt   <= S_IDLE;
            r_to_cnt    <= 16'd0;
            r_err       <= 2'd0;
            r_dev       <= 7'd0;
            r_reg       <= 8'd0;
            r_wdata     <= 8'd0;
            r_rnw       <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'd0;
            r_rsp_err   <= 2'd0;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_ack_in    <= 1'b0;
            r_din       <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_gap_tgt   <= w_gap_tgt_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_err       <= w_err_nxt;
            if (w_latch) begin
                r_dev   <= req_dev;
                r_reg   <= req_reg;
                r_wdata <= req_wdata;
                r_rnw   <= req_rnw;
            end
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_DONE);
            r_rsp_rdata <= w_rdata_nxt;
            r_rsp_err   <= (w_state_nxt == S_DONE) ? w_err_nxt : r_rsp_err;
            r_start     <= w_start_nxt;
            r_stop      <= w_stop_nxt;
            r_read      <= w_read_nxt;
            r_write     <= w_write_nxt;
            r_ack_in    <= w_ack_in_nxt;
            r_din       <= w_din_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign start     = r_start;
    assign stop      = r_stop;
    assign read      = r_read;
    assign write     = r_write;
    assign ack_in    = r_ack_in;
    assign din       = r_din;

endmodule

`default_nettype wire

// File: tb/tb_n101_i2c_master_xfer_seq.sv
// ============================================================================
//  Module      : tb_n101_i2c_master_xfer_seq
//  Description : Directed self-checking bench for the I2C transfer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_n101_i2c_master_xfer_seq;

    localparam logic [4:0] c_devw  = 5'b10010; // {start,stop,read,write,ack_in}
    localparam logic [4:0] c_regw  = 5'b00010;
    localparam logic [4:0] c_dataw = 5'b01010;
    localparam logic [4:0] c_rd    = 5'b01101;
    localparam logic [4:0] c_stop  = 5'b01000;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_rnw;
    logic [6:0] req_dev;
    logic [7:0] req_reg, req_wdata;
    logic       req_ready, rsp_valid, busy;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       start, stop, read, write, ack_in;
    logic [7:0] din;
    logic       cmd_ack, ack_out, i2c_al;
    logic [7:0] dout;
    logic [4:0] cmd;

    int n_chk  = 0;
    int n_fail = 0;

    assign cmd = {start, stop, read, write, ack_in};

    always #5 clk = ~clk;

    n101_i2c_master_xfer_seq #(.TO_CYCLES(16'd16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rnw   (req_rnw),
        .req_dev   (req_dev),
        .req_reg   (req_reg),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .start     (start),
        .stop      (stop),
        .read      (read),
        .write     (write),
        .ack_in    (ack_in),
        .din       (din),
        .cmd_ack   (cmd_ack),
        .ack_out   (ack_out),
        .i2c_al    (i2c_al),
        .dout      (dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, "_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_din"},   32'(din),       32'd0);
        chk({tag, "_cmd"},   32'(cmd),       32'd0);
    endtask

    // Called at a negedge while idle; fields are scrambled after acceptance
    task automatic issue(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd);
        chk("issue_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_rnw   = rnw;
        req_dev   = dev;
        req_reg   = rg;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_rnw   = ~rnw;
        req_dev   = ~dev;
        req_reg   = ~rg;
        req_wdata = ~wd;
        chk("issue_busy", 32'(busy), 32'd1);
    endtask

    // Wait for a command, check it, hold it, then acknowledge it
    task automatic xfer_cmd(input string tag, input logic [4:0] exp_cmd, input int exp_din,
                            input int exp_wait, input int hold, input logic nack,
                            input logic [7:0] rd_byte);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cmd == 5'd0 && n < 40);
        chk({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd));
        if (exp_din >= 0) chk({tag, "_din"}, 32'(din), exp_din);
        if (exp_wait > 0) chk({tag, "_gap"}, n, exp_wait);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, 32'(cmd), 32'(exp_cmd));
        end
        cmd_ack = 1'b1;
        ack_out = nack;
        dout    = rd_byte;
        @(negedge clk);
        cmd_ack = 1'b0;
        ack_out = 1'b0;
        dout    = 8'h00;
        chk({tag, "_after_ack"}, 32'(cmd), 32'd0);
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] err, input logic [7:0] rdata);
        chk({tag, "_rspv"},  32'(rsp_valid), 32'd1);
        chk({tag, "_err"},   32'(rsp_err),   32'(err));
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(rdata));
        @(negedge clk);
        chk({tag, "_rspv_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready"},      32'(req_ready), 32'd1);
        chk({tag, "_cmd_idle"},   32'(cmd),       32'd0);
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cmd == 5'd0 && n < 40);
    endtask

    initial begin
        int n;
        int bad;
        int rsp_seen;
        rst = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_dev = 7'd0; req_reg = 8'd0;
        req_wdata = 8'd0; cmd_ack = 1'b0; ack_out = 1'b0; i2c_al = 1'b0; dout = 8'd0;
        repeat (3) @(negedge clk);
        chk_idle_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Register write, all ACK
        issue(1'b0, 7'h50, 8'h10, 8'hA5);
        xfer_cmd("w_dev",  c_devw,  'hA0, 0, 0, 1'b0, 8'h00);
        xfer_cmd("w_reg",  c_regw,  'h10, 1, 2, 1'b0, 8'h00);
        xfer_cmd("w_data", c_dataw, 'hA5, 1, 0, 1'b0, 8'h00);
        chk_rsp("wr", 2'd0, 8'h00);

        // Register read returning 0x3C
        issue(1'b1, 7'h50, 8'h02, 8'h00);
        xfer_cmd("r_dev",  c_devw, 'hA0, 0, 0, 1'b0, 8'h00);
        xfer_cmd("r_reg",  c_regw, 'h02, 1, 0, 1'b0, 8'h00);
        xfer_cmd("r_devr", c_devw, 'hA1, 1, 0, 1'b0, 8'h00);
        xfer_cmd("r_rd",   c_rd,   -1,   1, 1, 1'b0, 8'h3C);
        chk_rsp("rd", 2'd0, 8'h3C);

        // Address NACK: STOP-only command follows, register phase skipped
        issue(1'b0, 7'h22, 8'h01, 8'h77);
        xfer_cmd("n_dev",  c_devw, 'h44, 0, 0, 1'b1, 8'h00);
        xfer_cmd("n_stop", c_stop, -1,   1, 0, 1'b0, 8'h00);
        chk_rsp("nack", 2'd1, 8'h3C);

        // Arbitration lost during register phase, coincident with cmd_ack
        issue(1'b0, 7'h11, 8'h33, 8'h55);
        xfer_cmd("a_dev", c_devw, 'h22, 0, 0, 1'b0, 8'h00);
        wait_cmd(n);
        chk("a_reg_cmd", 32'(cmd), 32'(c_regw));
        i2c_al  = 1'b1;
        cmd_ack = 1'b1;
        @(negedge clk);
        i2c_al  = 1'b0;
        cmd_ack = 1'b0;
        chk("a_cmd_cleared", 32'(cmd), 32'd0);
        chk_rsp("al", 2'd2, 8'h3C);

        // Timeout: cmd_ack withheld, response on the 16th waiting cycle
        issue(1'b0, 7'h7F, 8'h00, 8'h00);
        n   = 1;
        bad = 0;
        while (!rsp_valid && n < 40) begin
            if (cmd !== c_devw) bad++;
            @(negedge clk);
            n++;
        end
        chk("to_cycle", n, 16);
        chk("to_cmd_held", bad, 0);
        chk("to_cmd_cleared", 32'(cmd), 32'd0);
        chk_rsp("to", 2'd3, 8'h3C);

        // Reset in the data phase, then a clean read
        issue(1'b0, 7'h50, 8'h10, 8'h5A);
        xfer_cmd("x_dev", c_devw, 'hA0, 0, 0, 1'b0, 8'h00);
        xfer_cmd("x_reg", c_regw, 'h10, 1, 0, 1'b0, 8'h00);
        wait_cmd(n);
        chk("x_data_cmd", 32'(cmd), 32'(c_dataw));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_reset("x_rst");
        rsp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        chk("x_no_rsp", rsp_seen, 0);
        issue(1'b1, 7'h50, 8'h02, 8'h00);
        xfer_cmd("y_dev",  c_devw, 'hA0, 0, 0, 1'b0, 8'h00);
        xfer_cmd("y_reg",  c_regw, 'h02, 1, 0, 1'b0, 8'h00);
        xfer_cmd("y_devr", c_devw, 'hA1, 1, 0, 1'b0, 8'h00);
        xfer_cmd("y_rd",   c_rd,   -1,   1, 0, 1'b0, 8'h96);
        chk_rsp("rd2", 2'd0, 8'h96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
